// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequences one convolver frame - kernel bank, clear pulse, activation stream and result hand-off
module conv_seq_ctrl #(
   parameter int N         = 10,
   parameter int K         = 5,
   parameter int DW        = 16,
   parameter int AW        = 32,
   parameter int FLUSH_MAX = 2*K
) (
   input  logic                   clk,
   input  logic                   global_rst_n,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   input  logic                   wt_wr_en,
   input  logic [$clog2(K*K)-1:0] wt_wr_addr,
   input  logic [DW-1:0]          wt_wr_data,
   input  logic                   act_valid,
   output logic                   act_ready,
   input  logic [DW-1:0]          act_data,
   output logic                   conv_rst,
   output logic                   conv_ce,
   output logic [K*K*DW-1:0]      conv_weight,
   output logic [DW-1:0]          conv_activation,
   input  logic [AW-1:0]          conv_op,
   input  logic                   conv_valid,
   input  logic                   conv_end,
   output logic                   res_valid,
   output logic [AW-1:0]          res_data,
   output logic                   res_last,
   input  logic                   res_ready
);
   localparam int KK   = K*K;
   localparam int NN   = N*N;
   localparam int OUTS = (N-K+1)*(N-K+1);
   localparam int AD   = $clog2(KK);
   localparam int AD1  = AD + 1;
   localparam int IW   = $clog2(NN+1);
   localparam int OW   = $clog2(OUTS+1);
   localparam int FW   = $clog2(FLUSH_MAX+1);
   localparam logic [IW-1:0] IN_LAST  = IW'(NN-1);
   localparam logic [OW-1:0] OUT_N    = OW'(OUTS);
   localparam logic [OW-1:0] OUT_LAST = OW'(OUTS-1);
   localparam logic [FW-1:0] FL_MAX   = FW'(FLUSH_MAX);
   localparam logic [AD:0]   KK_W     = AD1'(KK);

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, FLUSH, DONE} state_t;

   state_t        state, state_n;
   logic [DW-1:0] bank [KK];
   logic [IW-1:0] in_cnt;
   logic [OW-1:0] out_cnt;
   logic [FW-1:0] flush_cnt;
   logic          clr_cnt, set_err, cap;

   assign cap             = conv_ce & conv_valid & ~conv_end;
   assign busy            = state != IDLE;
   assign done            = state == DONE;
   assign conv_activation = (state == RUN && conv_ce) ? act_data : '0;

   for (genvar g = 0; g < KK; g++) begin : g_w
      assign conv_weight[g*DW +: DW] = bank[g];
   end

   // state register
   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) state <= IDLE;
      else state <= state_n;
   end

   // next state and per-state strobes; a premature conv_end or an accepted last result ends the frame
   always_comb begin
      state_n   = state;
      act_ready = 1'b0;
      conv_ce   = 1'b0;
      conv_rst  = 1'b0;
      set_err   = 1'b0;
      case (state)
         IDLE:  state_n = start ? CLEAR : IDLE;
         CLEAR: begin
            conv_rst = 1'b1;
            state_n  = clr_cnt ? RUN : CLEAR;
         end
         RUN: begin
            act_ready = res_ready;
            conv_ce   = act_valid & res_ready;
            state_n   = (conv_ce && in_cnt == IN_LAST) ? FLUSH : RUN;
         end
         FLUSH: begin
            conv_ce = res_ready & (flush_cnt != FL_MAX);
            if (flush_cnt == FL_MAX && out_cnt != OUT_N) begin
               set_err = 1'b1;
               state_n = DONE;
            end
         end
         default: state_n = IDLE;
      endcase
      if (state == RUN || state == FLUSH) begin
         if (conv_ce && conv_end && out_cnt != OUT_N) begin
            set_err = 1'b1;
            state_n = DONE;
         end else if (res_valid && res_ready && res_last) begin
            state_n = DONE;
         end
      end
   end

   // kernel bank: writable only while idle, out-of-range entries dropped
   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         for (int i = 0; i < KK; i++) bank[i] <= '0;
      end else if (state == IDLE && wt_wr_en && {1'b0, wt_wr_addr} < KK_W) begin
         bank[wt_wr_addr] <= wt_wr_data;
      end
   end

   // frame counters, sticky error and the single-entry result holding register
   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         clr_cnt   <= 1'b0;
         in_cnt    <= '0;
         out_cnt   <= '0;
         flush_cnt <= '0;
         err       <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_last  <= 1'b0;
      end else begin
         clr_cnt   <= state == CLEAR && !clr_cnt;
         res_valid <= state != DONE && (cap || (res_valid && !res_ready));
         res_last  <= cap ? out_cnt == OUT_LAST : res_last && state != DONE && !res_ready;
         if (cap) res_data <= conv_op;
         if (state == IDLE && start) begin
            in_cnt    <= '0;
            out_cnt   <= '0;
            flush_cnt <= '0;
            err       <= 1'b0;
         end else begin
            if (state == RUN && conv_ce) in_cnt <= in_cnt + 1'b1;
            if (state == FLUSH && conv_ce) flush_cnt <= flush_cnt + 1'b1;
            if (cap && out_cnt != OUT_N) out_cnt <= out_cnt + 1'b1;
            if (set_err) err <= 1'b1;
         end
      end
   end
endmodule
